payload_len_chk: RTL and testbench

Receive-side counterpart of the transmitter's payload splitter. It is loaded with the total byte count the pattern generator was told to send, then watches the MAC receive AXI-Stream. For each frame it recomputes the payload length the transmitter must have used, applying the same split rule, and compares it against the counted frame length. It keeps the running remainder, frame and error counts, and signals completion. It sits between the tri-mode MAC rx stream and the checker/status logic.

---
 rtl/payload_pkg.sv | 30 +++
 rtl/payload_len_chk.sv | 107 ++++++++++
 tb/tb_payload_len_chk.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/payload_pkg.sv
// Shared payload split rule and FSM state type, used by both the tx splitter and the rx length checker
// so the two sides always agree on the frame sequence for a given byte total.
package payload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_PAYLOAD  = 1500;
  localparam int SPLIT_THRESH = 1600;

  // Above the threshold send a full frame; between max and threshold split the tail
  // into two roughly equal frames so the last one is never a tiny runt.
  function automatic logic [31:0] exp_payload(
    input logic [31:0] remain,
    input logic [31:0] max_payload  = MAX_PAYLOAD,
    input logic [31:0] split_thresh = SPLIT_THRESH
  );
    if (remain > split_thresh) begin
      return max_payload;
    end else if (remain > max_payload) begin
      return remain >> 1;
    end else begin
      return remain;
    end
  endfunction

endpackage

// File: rtl/payload_len_chk.sv
// Rx payload length checker: results visible one cycle after the rx_tlast beat.
// No backpressure: every rx_tvalid beat is consumed; beats outside RECV only raise overrun.
module payload_len_chk #(
  parameter int W            = 16,
  parameter int MAX_PAYLOAD  = payload_pkg::MAX_PAYLOAD,
  parameter int SPLIT_THRESH = payload_pkg::SPLIT_THRESH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] number_of_bytes,
  input  logic         rx_tvalid,
  input  logic         rx_tlast,
  input  logic         rx_tuser,
  output logic         busy,
  output logic         done,
  output logic         frame_ok,
  output logic         len_err,
  output logic         overrun,
  output logic [W-1:0] rx_len,
  output logic [W-1:0] exp_len,
  output logic [W-1:0] remain,
  output logic [W-1:0] frame_cnt,
  output logic [W-1:0] err_cnt
);
  import payload_pkg::*;

  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] ONE      = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] byte_cnt;
  logic [W-1:0] frame_len;
  logic [W-1:0] remain_nxt;
  logic         last_beat;

  assign exp_len    = W'(exp_payload(32'(remain), 32'(MAX_PAYLOAD), 32'(SPLIT_THRESH)));
  assign frame_len  = (byte_cnt == ALL_ONES) ? ALL_ONES : byte_cnt + ONE;
  assign remain_nxt = remain - exp_len;
  assign last_beat  = (state_q == RECV) && rx_tvalid && rx_tlast && !start;

  assign busy = (state_q == RECV);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (number_of_bytes == '0) ? DONE : RECV;
    end else if (last_beat && (remain_nxt == '0)) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      rx_len    <= '0;
      remain    <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      frame_ok  <= 1'b0;
      len_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_ok <= 1'b0;
      len_err  <= 1'b0;
      overrun  <= 1'b0;
      if (start) begin
        // Also an abort when in RECV: the partial frame vanishes without a pulse.
        remain    <= number_of_bytes;
        byte_cnt  <= '0;
        frame_cnt <= '0;
        err_cnt   <= '0;
        rx_len    <= '0;
      end else if (rx_tvalid) begin
        if (state_q != RECV) begin
          overrun <= 1'b1;
        end else if (rx_tlast) begin
          rx_len    <= frame_len;
          frame_cnt <= frame_cnt + ONE;
          byte_cnt  <= '0;
          // Always step by the expected length to stay aligned with the transmitter.
          remain    <= remain_nxt;
          if ((frame_len == exp_len) && !rx_tuser) begin
            frame_ok <= 1'b1;
          end else begin
            len_err <= 1'b1;
            if (err_cnt != ALL_ONES) begin
              err_cnt <= err_cnt + ONE;
            end
          end
        end else if (byte_cnt != ALL_ONES) begin
          byte_cnt <= byte_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_payload_len_chk.sv
// Directed bench for payload_len_chk: inputs driven and outputs sampled on the falling edge.
module tb_payload_len_chk;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] number_of_bytes;
  logic         rx_tvalid;
  logic         rx_tlast;
  logic         rx_tuser;
  logic         busy;
  logic         done;
  logic         frame_ok;
  logic         len_err;
  logic         overrun;
  logic [W-1:0] rx_len;
  logic [W-1:0] exp_len;
  logic [W-1:0] remain;
  logic [W-1:0] frame_cnt;
  logic [W-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  payload_len_chk #(.W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .number_of_bytes (number_of_bytes),
    .rx_tvalid       (rx_tvalid),
    .rx_tlast        (rx_tlast),
    .rx_tuser        (rx_tuser),
    .busy            (busy),
    .done            (done),
    .frame_ok        (frame_ok),
    .len_err         (len_err),
    .overrun         (overrun),
    .rx_len          (rx_len),
    .exp_len         (exp_len),
    .remain          (remain),
    .frame_cnt       (frame_cnt),
    .err_cnt         (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Returns on the falling edge right after the edge that sampled the last start cycle.
  task automatic do_start(input int n);
    @(negedge clk);
    start           = 1'b1;
    number_of_bytes = W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends n back-to-back beats; returns on the falling edge where the tlast results are visible.
  task automatic send_frame(input int n, input logic tuser, input logic with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_tvalid = 1'b1;
      rx_tlast  = with_last && (i == n - 1);
      rx_tuser  = with_last && (i == n - 1) && tuser;
    end
    @(negedge clk);
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_frame_ok"},  32'(frame_ok),  0);
    chk({tag, "_len_err"},   32'(len_err),   0);
    chk({tag, "_overrun"},   32'(overrun),   0);
    chk({tag, "_rx_len"},    32'(rx_len),    0);
    chk({tag, "_remain"},    32'(remain),    0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   0);
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    number_of_bytes = '0;
    rx_tvalid       = 1'b0;
    rx_tlast        = 1'b0;
    rx_tuser        = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Three-frame split of 3001 bytes: 1500, 750, 751.
    do_start(3001);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_remain0", 32'(remain), 3001);
    chk("t1_exp0", 32'(exp_len), 1500);
    send_frame(1500, 1'b0, 1'b1);
    chk("t1_ok1", 32'(frame_ok), 1);
    chk("t1_remain1", 32'(remain), 1501);
    chk("t1_exp1", 32'(exp_len), 750);
    @(negedge clk);
    chk("t1_ok1_width", 32'(frame_ok), 0);
    send_frame(750, 1'b0, 1'b1);
    chk("t1_ok2", 32'(frame_ok), 1);
    chk("t1_remain2", 32'(remain), 751);
    chk("t1_exp2", 32'(exp_len), 751);
    send_frame(751, 1'b0, 1'b1);
    chk("t1_ok3", 32'(frame_ok), 1);
    chk("t1_err3", 32'(len_err), 0);
    chk("t1_remain3", 32'(remain), 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_frame_cnt", 32'(frame_cnt), 3);
    chk("t1_err_cnt", 32'(err_cnt), 0);
    chk("t1_rx_len", 32'(rx_len), 751);

    // Stray beat while DONE.
    @(negedge clk);
    rx_tvalid = 1'b1;
    @(negedge clk);
    rx_tvalid = 1'b0;
    chk("stray_overrun", 32'(overrun), 1);
    chk("stray_frame_cnt", 32'(frame_cnt), 3);
    chk("stray_remain", 32'(remain), 0);
    chk("stray_done", 32'(done), 1);
    @(negedge clk);
    chk("stray_overrun_width", 32'(overrun), 0);

    // Split-rule boundaries around the threshold and max payload.
    do_start(1601);
    chk("rule_1601", 32'(exp_len), 1500);
    do_start(1600);
    chk("rule_1600", 32'(exp_len), 800);
    do_start(1501);
    chk("rule_1501", 32'(exp_len), 750);
    do_start(1500);
    chk("rule_1500", 32'(exp_len), 1500);

    // Short frame.
    do_start(1000);
    chk("t2_frame_cnt_clr", 32'(frame_cnt), 0);
    send_frame(999, 1'b0, 1'b1);
    chk("t2_len_err", 32'(len_err), 1);
    chk("t2_frame_ok", 32'(frame_ok), 0);
    chk("t2_err_cnt", 32'(err_cnt), 1);
    chk("t2_rx_len", 32'(rx_len), 999);
    chk("t2_remain", 32'(remain), 0);
    chk("t2_done", 32'(done), 1);

    // Correct length but MAC flags the frame bad.
    do_start(64);
    chk("t3_err_cnt_clr", 32'(err_cnt), 0);
    send_frame(64, 1'b1, 1'b1);
    chk("t3_len_err", 32'(len_err), 1);
    chk("t3_frame_ok", 32'(frame_ok), 0);
    chk("t3_err_cnt", 32'(err_cnt), 1);
    chk("t3_done", 32'(done), 1);

    // Zero total goes straight to DONE.
    do_start(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_remain", 32'(remain), 0);

    // Abort mid-frame, with a beat colliding with start.
    do_start(2000);
    send_frame(300, 1'b0, 1'b0);
    @(negedge clk);
    rx_tvalid       = 1'b1;
    start           = 1'b1;
    number_of_bytes = W'(100);
    @(negedge clk);
    rx_tvalid = 1'b0;
    start     = 1'b0;
    chk("abort_ok", 32'(frame_ok), 0);
    chk("abort_err", 32'(len_err), 0);
    chk("abort_remain", 32'(remain), 100);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_frame_cnt", 32'(frame_cnt), 0);
    send_frame(100, 1'b0, 1'b1);
    chk("abort_ok2", 32'(frame_ok), 1);
    chk("abort_rx_len", 32'(rx_len), 100);
    chk("abort_done", 32'(done), 1);
    chk("abort_frame_cnt2", 32'(frame_cnt), 1);

    // Reset in the middle of a run.
    do_start(500);
    send_frame(10, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    do_start(5);
    send_frame(5, 1'b0, 1'b1);
    chk("post_rst_ok", 32'(frame_ok), 1);
    chk("post_rst_done", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
